// File: rtl/count_checker_pkg.sv
// Shared types and constants for the count_checker block: FSM state encoding,
// error counter width and parameter defaults.
package count_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    localparam int ERR_W              = 16;
    localparam int GOOD_W             = 4;
    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_LOCK_COUNT = 4;

endpackage

// File: rtl/count_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/count_checker.sv
// Monitors an external up-counter: acquires lock after LOCK_COUNT consecutive
// increments, flags sequence errors and restarts-to-zero, counts errors.
module count_checker
    import count_checker_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int LOCK_COUNT = DEFAULT_LOCK_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic             restart_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected,
    output logic [1:0]       state
);

    localparam logic [GOOD_W-1:0] LOCK_GOOD = GOOD_W'(LOCK_COUNT);

    // Reset asserts asynchronously but releases only after two clean clock edges.
    logic [1:0] rst_sync_reg;
    logic       rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_reg[1];

    state_t            state_reg, state_next;
    logic [GOOD_W-1:0] good_reg, good_next, good_inc;
    logic [WIDTH-1:0]  expected_reg, expected_next;
    logic              locked_reg, err_pulse_reg, restart_pulse_reg;
    logic              err_next, restart_next, match;

    assign match = (cnt_in == expected_reg);

    always_comb begin
        state_next    = state_reg;
        good_next     = good_reg;
        expected_next = expected_reg;
        err_next      = 1'b0;
        restart_next  = 1'b0;
        good_inc      = good_reg + GOOD_W'(1);
        if (en) begin
            expected_next = cnt_in + WIDTH'(1);
            case (state_reg)
                ST_IDLE: begin
                    good_next  = GOOD_W'(1);
                    state_next = ST_ACQUIRE;
                end
                ST_ACQUIRE, ST_LOST: begin
                    if (match) begin
                        good_next = good_inc;
                        if (good_inc == LOCK_GOOD) begin
                            state_next = ST_LOCKED;
                        end
                    end else begin
                        good_next = GOOD_W'(1);
                        err_next  = (state_reg == ST_LOST);
                    end
                end
                ST_LOCKED: begin
                    if (!match) begin
                        good_next = GOOD_W'(1);
                        // A jump back to zero is a legitimate counter restart, not an error.
                        if (cnt_in == '0) begin
                            restart_next = 1'b1;
                            state_next   = ST_ACQUIRE;
                        end else begin
                            err_next   = 1'b1;
                            state_next = ST_LOST;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_IDLE;
            good_reg          <= '0;
            expected_reg      <= '0;
            locked_reg        <= 1'b0;
            err_pulse_reg     <= 1'b0;
            restart_pulse_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            good_reg          <= good_next;
            expected_reg      <= expected_next;
            locked_reg        <= (state_next == ST_LOCKED);
            err_pulse_reg     <= err_next;
            restart_pulse_reg <= restart_next;
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_next),
        .clr   (clr),
        .count (err_count)
    );

    assign locked        = locked_reg;
    assign err_pulse     = err_pulse_reg;
    assign restart_pulse = restart_pulse_reg;
    assign expected      = expected_reg;
    assign state         = state_reg;

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: lock, wrap, restart, loss/relock,
// error saturation and clear, asynchronous reset mid-sequence.
`timescale 1ns/1ps
module tb_count_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  cnt_in = 8'h00;
    logic        clr = 1'b0;
    logic        locked, err_pulse, restart_pulse;
    logic [15:0] err_count;
    logic [7:0]  expected;
    logic [1:0]  state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    count_checker #(.WIDTH(8), .LOCK_COUNT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .cnt_in        (cnt_in),
        .clr           (clr),
        .locked        (locked),
        .err_pulse     (err_pulse),
        .restart_pulse (restart_pulse),
        .err_count     (err_count),
        .expected      (expected),
        .state         (state)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Apply one sample and return 1ns after the clock edge that takes it.
    task automatic step(input logic e, input logic [7:0] c, input logic cl);
        en = e;
        cnt_in = c;
        clr = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held low
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_locked", 32'(locked), 32'd0);
        check_val("rst_expected", 32'(expected), 32'd0);
        check_val("rst_err_count", 32'(err_count), 32'd0);
        check_val("rst_pulses", 32'({err_pulse, restart_pulse}), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);
        check_val("idle_after_release", 32'(state), 32'd0);

        // Acquire lock on 0,1,2,3
        step(1'b1, 8'h00, 1'b0);
        check_val("acq_s0_state", 32'(state), 32'd1);
        check_val("acq_s0_expected", 32'(expected), 32'h01);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        check_val("acq_s2_state", 32'(state), 32'd1);
        check_val("acq_s2_locked", 32'(locked), 32'd0);
        step(1'b1, 8'h03, 1'b0);
        check_val("lock_locked", 32'(locked), 32'd1);
        check_val("lock_state", 32'(state), 32'd2);
        check_val("lock_err_count", 32'(err_count), 32'd0);

        // en=0 holds everything, even with a bogus cnt_in
        step(1'b0, 8'h99, 1'b0);
        check_val("hold_state", 32'(state), 32'd2);
        check_val("hold_expected", 32'(expected), 32'h04);
        check_val("hold_pulses", 32'({err_pulse, restart_pulse}), 32'd0);

        // Run up through the wrap
        for (int v = 4; v <= 8'hFD; v++) step(1'b1, 8'(v), 1'b0);
        step(1'b1, 8'hFE, 1'b0);
        check_val("wrap_FE_locked", 32'(locked), 32'd1);
        step(1'b1, 8'hFF, 1'b0);
        check_val("wrap_FF_locked", 32'(locked), 32'd1);
        check_val("wrap_FF_expected", 32'(expected), 32'h00);
        step(1'b1, 8'h00, 1'b0);
        check_val("wrap_00_locked", 32'(locked), 32'd1);
        check_val("wrap_00_pulses", 32'({err_pulse, restart_pulse}), 32'd0);
        step(1'b1, 8'h01, 1'b0);
        check_val("wrap_01_locked", 32'(locked), 32'd1);
        check_val("wrap_01_err_count", 32'(err_count), 32'd0);

        // Restart: expected=10, cnt_in=00
        for (int v = 2; v <= 8'h0F; v++) step(1'b1, 8'(v), 1'b0);
        check_val("pre_restart_expected", 32'(expected), 32'h10);
        step(1'b1, 8'h00, 1'b0);
        check_val("restart_pulse", 32'(restart_pulse), 32'd1);
        check_val("restart_state", 32'(state), 32'd1);
        check_val("restart_err_pulse", 32'(err_pulse), 32'd0);
        check_val("restart_err_count", 32'(err_count), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        check_val("restart_pulse_drop", 32'(restart_pulse), 32'd0);

        // Relock from the restart, then a real error
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        check_val("relock_s2_state", 32'(state), 32'd1);
        step(1'b1, 8'h03, 1'b0);
        check_val("relock_state", 32'(state), 32'd2);
        for (int v = 4; v <= 8'h0F; v++) step(1'b1, 8'(v), 1'b0);
        step(1'b1, 8'h22, 1'b0);
        check_val("lost_err_pulse", 32'(err_pulse), 32'd1);
        check_val("lost_err_count", 32'(err_count), 32'd1);
        check_val("lost_state", 32'(state), 32'd3);
        check_val("lost_locked", 32'(locked), 32'd0);
        check_val("lost_expected", 32'(expected), 32'h23);
        step(1'b0, 8'h00, 1'b0);
        check_val("lost_hold_pulse", 32'(err_pulse), 32'd0);
        check_val("lost_hold_expected", 32'(expected), 32'h23);
        step(1'b1, 8'h23, 1'b0);
        check_val("lost_23_state", 32'(state), 32'd3);
        step(1'b1, 8'h24, 1'b0);
        check_val("lost_24_state", 32'(state), 32'd3);
        step(1'b1, 8'h25, 1'b0);
        check_val("lost_25_state", 32'(state), 32'd2);
        check_val("lost_25_locked", 32'(locked), 32'd1);
        check_val("lost_25_err_pulse", 32'(err_pulse), 32'd0);

        // Saturation: constant cnt_in never matches
        step(1'b1, 8'h50, 1'b0);
        check_val("sat_first_err_count", 32'(err_count), 32'd2);
        check_val("sat_first_state", 32'(state), 32'd3);
        for (int i = 0; i < 65533; i++) step(1'b1, 8'h50, 1'b0);
        check_val("sat_reach_ffff", 32'(err_count), 32'hFFFF);
        step(1'b1, 8'h50, 1'b0);
        check_val("sat_hold_ffff", 32'(err_count), 32'hFFFF);
        check_val("sat_err_pulse", 32'(err_pulse), 32'd1);
        step(1'b1, 8'h50, 1'b1);
        check_val("clr_err_count", 32'(err_count), 32'd0);
        check_val("clr_err_pulse", 32'(err_pulse), 32'd1);

        // Back to LOCKED, restart into ACQUIRE, then async reset
        step(1'b1, 8'h70, 1'b0);
        check_val("post_clr_err_count", 32'(err_count), 32'd1);
        step(1'b1, 8'h71, 1'b0);
        step(1'b1, 8'h72, 1'b0);
        step(1'b1, 8'h73, 1'b0);
        check_val("relock2_state", 32'(state), 32'd2);
        step(1'b1, 8'h00, 1'b0);
        check_val("acq2_state", 32'(state), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_val("async_rst_state", 32'(state), 32'd0);
        check_val("async_rst_expected", 32'(expected), 32'd0);
        check_val("async_rst_err_count", 32'(err_count), 32'd0);
        check_val("async_rst_locked", 32'(locked), 32'd0);
        check_val("async_rst_pulses", 32'({err_pulse, restart_pulse}), 32'd0);
        step(1'b1, 8'h40, 1'b0);
        check_val("rst_low_hold_state", 32'(state), 32'd0);
        rst = 1'b1;
        begin
            bit entered = 1'b0;
            for (int i = 0; i < 5 && !entered; i++) begin
                step(1'b1, 8'h40, 1'b0);
                if (state != 2'd0) entered = 1'b1;
            end
            check_val("rerelease_entered", 32'(entered), 32'd1);
        end
        check_val("rerelease_state", 32'(state), 32'd1);
        check_val("rerelease_expected", 32'(expected), 32'h41);
        step(1'b1, 8'h41, 1'b0);
        step(1'b1, 8'h42, 1'b0);
        check_val("rerelease_good2_state", 32'(state), 32'd1);
        step(1'b1, 8'h43, 1'b0);
        check_val("rerelease_lock_state", 32'(state), 32'd2);
        check_val("rerelease_lock_locked", 32'(locked), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
